// File: rtl/ultrasonic_echo_meter_if.sv
// rtl/ultrasonic_echo_meter_if.sv - sensor pins and ranging results of the echo meter
interface ultrasonic_echo_meter_if #(
  parameter int DIST_W = 9
);
  logic              enable;
  logic              echo;
  logic              trigger;
  logic [DIST_W-1:0] distance_cm;
  logic              dist_valid;
  logic              timeout;
  logic              busy;

  modport master (
    input  enable, echo,
    output trigger, distance_cm, dist_valid, timeout, busy
  );

  modport slave (
    output enable, echo,
    input  trigger, distance_cm, dist_valid, timeout, busy
  );
endinterface

// File: rtl/ultrasonic_echo_meter.sv
// rtl/ultrasonic_echo_meter.sv - periodic HC-SR04 trigger/echo timer with cm conversion
module ultrasonic_echo_meter #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int MAX_CM         = 400,
  parameter int DIST_W         = 9
) (
  input logic                   clk_in,
  input logic                   rst,
  ultrasonic_echo_meter_if.master io
);
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = (CYCLES_PER_CM > 2) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [PW-1:0]     TRIG_LAST   = PW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0]     PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0]     TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]     SUB_LAST    = SW'(CYCLES_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX      = DIST_W'(MAX_CM);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

  state_t            state;
  logic              echo_m, echo_s, echo_d;
  logic [PW-1:0]     period_cnt;
  logic [TW-1:0]     to_cnt;
  logic [SW-1:0]     sub_cnt;
  logic [DIST_W-1:0] cm_cnt;
  logic              trigger, dist_valid, timeout, busy;
  logic [DIST_W-1:0] distance_cm;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      echo_m <= io.echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      period_cnt  <= '0;
      to_cnt      <= '0;
      sub_cnt     <= '0;
      cm_cnt      <= '0;
      trigger     <= 1'b0;
      distance_cm <= '0;
      dist_valid  <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      if (state != IDLE) period_cnt <= period_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (io.enable) begin
            state      <= TRIG;
            trigger    <= 1'b1;
            busy       <= 1'b1;
            period_cnt <= '0;
          end
        end
        TRIG: begin
          if (period_cnt == TRIG_LAST) begin
            state   <= WAIT_ECHO;
            trigger <= 1'b0;
            to_cnt  <= '0;
          end
        end
        WAIT_ECHO: begin
          to_cnt <= to_cnt + 1'b1;
          // Timeout first so to_cnt can never run past its last value in MEASURE.
          if (to_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end else if (echo_s && !echo_d) begin
            // The rise cycle is itself the first high cycle of the pulse.
            state   <= MEASURE;
            sub_cnt <= SW'(1);
            cm_cnt  <= '0;
          end
        end
        MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          if (!echo_s) begin
            distance_cm <= cm_cnt;
            dist_valid  <= 1'b1;
            state       <= HOLDOFF;
          end else if (to_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end else if (sub_cnt == SUB_LAST) begin
            sub_cnt <= '0;
            if (cm_cnt != CM_MAX) cm_cnt <= cm_cnt + 1'b1;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (period_cnt == PERIOD_LAST) begin
            if (io.enable) begin
              state      <= TRIG;
              trigger    <= 1'b1;
              period_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          trigger <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign io.trigger     = trigger;
  assign io.distance_cm = distance_cm;
  assign io.dist_valid  = dist_valid;
  assign io.timeout     = timeout;
  assign io.busy        = busy;
endmodule

// File: tb/tb_ultrasonic_echo_meter.sv
// tb/tb_ultrasonic_echo_meter.sv - directed self-checking bench for ultrasonic_echo_meter
module tb_ultrasonic_echo_meter;
  logic clk_in = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  ultrasonic_echo_meter_if #(.DIST_W(5)) bus ();

  ultrasonic_echo_meter #(
    .TRIG_CYCLES(4), .CYCLES_PER_CM(10), .TIMEOUT_CYCLES(300),
    .PERIOD_CYCLES(400), .MAX_CM(20), .DIST_W(5)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .io(bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_rise(output int t);
    logic prev;
    bit   found;
    prev  = bus.trigger;
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk_in);
      if (bus.trigger && !prev) begin
        found = 1'b1;
        t     = cyc;
      end
      prev = bus.trigger;
    end
    if (!found) chk("trigger_rise_seen", 0, 1);
  endtask

  task automatic wait_fall(output int t);
    bit found;
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_in);
      if (!bus.trigger) begin
        found = 1'b1;
        t     = cyc;
      end
    end
    if (!found) chk("trigger_fall_seen", 0, 1);
  endtask

  task automatic wait_timeout(input int t_entry, input string tag);
    int n;
    n = 0;
    while (!bus.timeout && n < 400) begin
      step(1);
      n++;
    end
    chk({tag, "_delay"}, cyc - t_entry, 300);
    chk({tag, "_no_valid"}, bus.dist_valid, 0);
    chk({tag, "_dist_held"}, bus.distance_cm, 20);
    step(1);
    chk({tag, "_one_cycle"}, bus.timeout, 0);
  endtask

  task automatic measure(input string tag, input int delay, input int width,
                         input int exp_cm, input int drop_at);
    step(delay);
    bus.echo = 1'b1;
    for (int i = 0; i < width; i++) begin
      step(1);
      if (i == drop_at) bus.enable = 1'b0;
    end
    bus.echo = 1'b0;
    step(2);
    chk({tag, "_valid_early"}, bus.dist_valid, 0);
    step(1);
    chk({tag, "_valid"}, bus.dist_valid, 1);
    chk({tag, "_dist"}, bus.distance_cm, exp_cm);
    chk({tag, "_timeout"}, bus.timeout, 0);
    step(1);
    chk({tag, "_valid_single"}, bus.dist_valid, 0);
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7, t8, tf, n;
    bit trig_seen;

    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.echo   = 1'b0;
    step(3);
    chk("rst_trigger", bus.trigger, 0);
    chk("rst_distance", bus.distance_cm, 0);
    chk("rst_valid", bus.dist_valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_busy", bus.busy, 0);
    bus.enable = 1'b1;
    step(2);
    chk("rst_holds_trigger", bus.trigger, 0);

    rst = 1'b0;
    wait_rise(t0);
    chk("first_rise_latency", t0 - cyc + 1, 1);
    chk("busy_in_trig", bus.busy, 1);
    wait_fall(tf);
    chk("trig_width", tf - t0, 4);
    measure("m57", 10, 57, 5, -1);

    wait_rise(t1);
    chk("period_1", t1 - t0, 400);
    wait_fall(tf);
    measure("m9", 10, 9, 0, -1);

    wait_rise(t2);
    chk("period_2", t2 - t1, 400);
    wait_fall(tf);
    measure("m10", 10, 10, 1, -1);

    wait_rise(t3);
    wait_fall(tf);
    measure("m250", 5, 250, 20, -1);

    wait_rise(t4);
    chk("period_4", t4 - t3, 400);
    wait_fall(tf);
    wait_timeout(tf, "no_echo");

    bus.echo = 1'b1;
    wait_rise(t5);
    chk("period_after_timeout", t5 - t4, 400);
    wait_fall(tf);
    wait_timeout(tf, "stale_echo");
    bus.echo = 1'b0;

    wait_rise(t6);
    chk("period_after_stale", t6 - t5, 400);
    wait_fall(tf);
    step(5);
    bus.echo = 1'b1;
    step(30);
    rst = 1'b1;
    #1;
    chk("rst_mid_measure_trigger", bus.trigger, 0);
    chk("rst_mid_measure_dist", bus.distance_cm, 0);
    chk("rst_mid_measure_busy", bus.busy, 0);
    bus.echo = 1'b0;
    step(2);
    rst = 1'b0;

    wait_rise(t7);
    rst = 1'b1;
    #1;
    chk("rst_mid_trig_trigger", bus.trigger, 0);
    step(2);
    rst = 1'b0;

    wait_rise(t8);
    wait_fall(tf);
    chk("trig_width_after_rst", tf - t8, 4);
    measure("m_drop", 10, 43, 4, 20);
    n = 0;
    while (bus.busy && n < 500) begin
      step(1);
      n++;
    end
    chk("drop_busy_low", bus.busy, 0);
    chk("drop_idle_time", cyc - t8, 400);
    trig_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.trigger) trig_seen = 1'b1;
    end
    chk("drop_no_trigger", trig_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
